// File: rtl/pdm_pkg.sv
// Shared constants and arithmetic helpers for the PDM playback modulator
// and the PDM-microphone decimator.
package pdm_pkg;

  // Default PCM sample width and integrator width.
  localparam int DEF_IN_WIDTH  = 16;
  localparam int DEF_ACC_WIDTH = 24;

  // Working width for saturating arithmetic; wide enough for any
  // integrator width this family uses plus headroom for one addition.
  localparam int SAT_W = 48;

  // Feedback levels at the default widths: +/- half of the PCM range.
  localparam logic signed [DEF_ACC_WIDTH-1:0] FS_POS =
    DEF_ACC_WIDTH'(1 <<< (DEF_IN_WIDTH - 1));
  localparam logic signed [DEF_ACC_WIDTH-1:0] FS_NEG = -FS_POS;

  // a + b clamped to the signed range of an acc_w-bit integrator.
  // Operands are supplied sign-extended to SAT_W bits; the caller narrows
  // the (already in-range) result back to acc_w bits.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int unsigned             acc_w
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = (SAT_W'(1) <<< (acc_w - 1)) - SAT_W'(1);
    lo  = -hi - SAT_W'(1);
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/sd2_core.sv
// Second-order 1-bit sigma-delta modulator running at the PDM clock.
// Two saturating integrators in cascade; the second one sees the freshly
// updated first-stage value so the noise transfer is (1 - z^-1)^2.
// While disabled the integrators are held at zero and the output toggles,
// which is the zero-valued idle pattern for a PDM sink.
module sd2_core
  import pdm_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic signed [IN_WIDTH-1:0] x_i,
  output logic                       pdm_o
);

  // Feedback magnitude: half the PCM range, i.e. digital full scale.
  localparam logic signed [SAT_W-1:0] FB_MAG = SAT_W'(1) <<< (IN_WIDTH - 1);

  logic signed [ACC_WIDTH-1:0] i1_q, i1_d;
  logic signed [ACC_WIDTH-1:0] i2_q, i2_d;
  logic                        pdm_q, pdm_d;
  logic signed [SAT_W-1:0]     fb;
  logic signed [SAT_W-1:0]     x_ext;

  // Next-state of both integrators and the quantiser.
  always_comb begin
    fb    = pdm_q ? FB_MAG : -FB_MAG;
    x_ext = SAT_W'(x_i);
    i1_d  = '0;
    i2_d  = '0;
    pdm_d = ~pdm_q;
    if (en) begin
      i1_d  = ACC_WIDTH'(sat_add(SAT_W'(i1_q), x_ext - fb, ACC_WIDTH));
      i2_d  = ACC_WIDTH'(sat_add(SAT_W'(i2_q), SAT_W'(i1_d) - fb, ACC_WIDTH));
      pdm_d = ~i2_d[ACC_WIDTH-1];
    end
  end

  // Integrator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q  <= '0;
      i2_q  <= '0;
      pdm_q <= 1'b0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      pdm_q <= pdm_d;
    end
  end

  assign pdm_o = pdm_q;

endmodule

// File: rtl/pdm_sd_modulator.sv
// PCM-to-PDM playback modulator. Accepts PCM samples at the decimated rate
// into a one-deep pending buffer, holds each sample for OSR PDM clocks,
// attenuates it by an arithmetic shift and drives the 2nd-order modulator.
//
// Handshake: a sample transfers on a clk edge where pcm_valid and pcm_ready
// are both high. pcm_ready is high only while enabled, out of reset and the
// pending buffer is empty; it does not depend on pcm_valid.
module pdm_sd_modulator
  import pdm_pkg::*;
#(
  parameter int OSR       = 64,
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [2:0]                 scale_shift,
  input  logic signed [IN_WIDTH-1:0] pcm_in,
  input  logic                       pcm_valid,
  output logic                       pcm_ready,
  output logic                       pdm_out,
  output logic                       sample_strobe,
  output logic                       underrun
);

  localparam int              PW         = $clog2(OSR);
  localparam logic [PW-1:0]   LAST_PHASE = PW'(OSR - 1);

  logic [PW-1:0]               phase_q, phase_d;
  logic signed [IN_WIDTH-1:0]  next_q, next_d;
  logic                        next_full_q, next_full_d;
  logic signed [IN_WIDTH-1:0]  hold_q, hold_d;
  logic                        strobe_q, strobe_d;
  logic                        underrun_q, underrun_d;
  logic                        run_q;
  logic                        load;
  logic                        xfer;
  logic signed [IN_WIDTH-1:0]  x;

  // run_q keeps pcm_ready low while reset is asserted even if en is high.
  assign pcm_ready = en & run_q & ~next_full_q;
  assign xfer      = pcm_valid & pcm_ready;
  assign load      = en & (phase_q == LAST_PHASE);

  // Buffer, hold and phase next-state. The modulator is fed from hold_d so
  // a sample loaded at a load point is used in that same cycle and shows on
  // pdm_out from the following cycle.
  always_comb begin
    phase_d     = en ? phase_q + PW'(1) : '0;
    next_d      = next_q;
    next_full_d = next_full_q;
    hold_d      = hold_q;
    strobe_d    = load & next_full_q;
    underrun_d  = load & ~next_full_q;
    if (!en) begin
      next_full_d = 1'b0;
      hold_d      = '0;
    end else begin
      if (load && next_full_q) begin
        hold_d      = next_q;
        next_full_d = 1'b0;
      end
      // Only possible with the buffer empty, so never collides with a load.
      if (xfer) begin
        next_d      = pcm_in;
        next_full_d = 1'b1;
      end
    end
    x = hold_d >>> scale_shift;
  end

  // Control and data registers of the input side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      next_q      <= '0;
      next_full_q <= 1'b0;
      hold_q      <= '0;
      strobe_q    <= 1'b0;
      underrun_q  <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      next_q      <= next_d;
      next_full_q <= next_full_d;
      hold_q      <= hold_d;
      strobe_q    <= strobe_d;
      underrun_q  <= underrun_d;
      run_q       <= 1'b1;
    end
  end

  sd2_core #(
    .IN_WIDTH (IN_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .x_i  (x),
    .pdm_o(pdm_out)
  );

  assign sample_strobe = strobe_q;
  assign underrun      = underrun_q;

endmodule
